// File: rtl/sirv_gnrl_wbck_rrarb_pkg.sv
// Shared defaults and index helpers for the writeback round-robin arbiter.
package sirv_gnrl_wbck_rrarb_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned AW_DEF   = 5;

    // Single-step modulo: callers only ever exceed n by less than n.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/sirv_gnrl_dfflr.sv
// Load-enabled flop bank with asynchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden_i,
    input  logic [DW-1:0] dnxt_i,
    output logic [DW-1:0] qout_o
);

    logic [DW-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (lden_i) begin
            q_q <= dnxt_i;
        end
    end

    assign qout_o = q_q;

endmodule

// File: rtl/sirv_gnrl_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module sirv_gnrl_rr_pick
    import sirv_gnrl_wbck_rrarb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [IW-1:0]   ptr_i,
    input  logic [NREQ-1:0] valid_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [IW-1:0]   win_idx_o,
    output logic            any_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = IW'(rr_wrap(int'(ptr_i) + off, NREQ));
            if (!found && valid_i[idx]) begin
                found         = 1'b1;
                win_idx_o     = idx;
                win_oh_o[idx] = 1'b1;
            end
        end
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/sirv_gnrl_wbck_rrarb.sv
// Round-robin arbiter sharing one regfile write port among NREQ writeback sources,
// with a single-entry output stage that accepts a new write while draining the old one.
module sirv_gnrl_wbck_rrarb
    import sirv_gnrl_wbck_rrarb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   i_valid,
    output logic [NREQ-1:0]   i_ready,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [NREQ*DW-1:0] i_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [AW-1:0]     o_addr,
    output logic [DW-1:0]     o_data,
    output logic [IW-1:0]     o_id
);

    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_d;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic            any_valid;
    logic            can_take;
    logic            accept;
    logic            drain;
    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign addr_arr[k] = i_addr[k*AW +: AW];
        assign data_arr[k] = i_data[k*DW +: DW];
    end

    sirv_gnrl_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .ptr_i     (ptr_q),
        .valid_i   (i_valid),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .any_o     (any_valid)
    );

    // Gating by rst_n keeps every i_ready low while reset is asserted.
    assign can_take = ~o_valid | o_ready;
    assign accept   = rst_n & any_valid & can_take;
    assign drain    = o_valid & o_ready & ~any_valid;
    assign i_ready  = accept ? win_oh : '0;
    assign ptr_d    = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

    sirv_gnrl_dfflr #(.DW(1)) u_vld_dff (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (accept | drain),
        .dnxt_i (accept),
        .qout_o (o_valid)
    );

    sirv_gnrl_dfflr #(.DW(AW)) u_addr_dff (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (accept),
        .dnxt_i (addr_arr[win_idx]),
        .qout_o (o_addr)
    );

    sirv_gnrl_dfflr #(.DW(DW)) u_data_dff (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (accept),
        .dnxt_i (data_arr[win_idx]),
        .qout_o (o_data)
    );

    sirv_gnrl_dfflr #(.DW(IW)) u_id_dff (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (accept),
        .dnxt_i (win_idx),
        .qout_o (o_id)
    );

    sirv_gnrl_dfflr #(.DW(IW)) u_ptr_dff (
        .clk    (clk),
        .rst_n  (rst_n),
        .lden_i (accept),
        .dnxt_i (ptr_d),
        .qout_o (ptr_q)
    );

endmodule
